// File: rtl/ula_param_seq.sv
// ula_param_seq: sequential ALU ("ULA") with a valid/ready input handshake,
// an iterative restoring divider, a post-ALU shifter and a held output register.
//
// Optional feature: define ULA_REMAINDER_EN to add output r (remainder of div;
// r = a on divide-by-zero, 0 for every other opcode).
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is high only in IDLE
//   crtl_ula [2:0]      opcode: add, sub, mul, div, and, or, not a, pass b
//   crtl_des [1:0]      shift mode: bypass, shl, lsr, rotl
//   des_amt  [SHW-1:0]  shift amount
//   a, b     [WIDTH-1:0] operands
//   c        [WIDTH-1:0] registered result
//   out_valid/out_ready output handshake; c and flags hold while out_ready=0
//   flag_z, flag_c, flag_v, flag_dz  zero, carry/borrow/mul-high, overflow, div-by-zero
module ula_param_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       crtl_ula,
  input  logic [1:0]       crtl_des,
  input  logic [SHW-1:0]   des_amt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz
`ifdef ULA_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] r
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DIV, HOLD} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_DIV  = 3'b011,
    OP_AND = 3'b100, OP_OR  = 3'b101, OP_NOTA = 3'b110, OP_PASSB = 3'b111
  } op_e;
  typedef enum logic [1:0] {SH_NONE, SH_LEFT, SH_RIGHT, SH_ROTL} shift_e;

  state_e state, state_next;

  // Captured operation
  op_e              op_q;
  shift_e           mode_q;
  logic [SHW-1:0]   amt_q;
  logic [WIDTH-1:0] a_q, b_q;

  // EXEC is two cycles: phase 0 registers the ALU stage, phase 1 shifts and
  // loads c. The divider joins at phase 1 with its quotient in res_q.
  logic             phase;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] div_q, div_r;
  logic [WIDTH-1:0] res_q;
  logic             fc_q, fv_q, dz_q;
`ifdef ULA_REMAINDER_EN
  logic [WIDTH-1:0] rem_q;
`endif

  // ALU stage
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_dz;

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};
  assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_dz  = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL: begin
        alu_res = prod[WIDTH-1:0];
        alu_c   = |prod[2*WIDTH-1:WIDTH];
      end
      // Only the b == 0 case reaches EXEC for div; real division runs in DIV.
      OP_DIV: begin
        alu_res = '1;
        alu_dz  = 1'b1;
      end
      OP_AND:   alu_res = a_q & b_q;
      OP_OR:    alu_res = a_q | b_q;
      OP_NOTA:  alu_res = ~a_q;
      OP_PASSB: alu_res = b_q;
      default:  alu_res = '0;
    endcase
  end

  // Restoring divider step: shift in next dividend bit, subtract if it fits.
  logic [WIDTH:0]   div_shift, div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_r_next, div_q_next;

  assign div_shift  = {div_r, div_q[WIDTH-1]};
  assign div_trial  = div_shift - {1'b0, b_q};
  assign div_ge     = ~div_trial[WIDTH];
  assign div_r_next = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_q_next = {div_q[WIDTH-2:0], div_ge};

  // Shifter on the registered ALU stage; rotation amount wraps modulo WIDTH.
  logic [31:0]        amt_mod;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH-1:0]   shifted;

  assign amt_mod = 32'(amt_q) % WIDTH;
  assign rot     = {res_q, res_q} << amt_mod;

  always_comb begin
    shifted = res_q;
    case (mode_q)
      SH_LEFT:  shifted = res_q << amt_q;
      SH_RIGHT: shifted = res_q >> amt_q;
      SH_ROTL:  shifted = rot[2*WIDTH-1:WIDTH];
      default:  shifted = res_q;
    endcase
  end

  // FSM state register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state and handshake output
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if ((op_e'(crtl_ula) == OP_DIV) && (b != '0)) state_next = DIV;
          else                                          state_next = EXEC;
        end
      end
      EXEC: if (phase)                      state_next = HOLD;
      DIV:  if (count == CW'(WIDTH - 1))    state_next = EXEC;
      HOLD: if (out_ready)                  state_next = IDLE;
      default:                              state_next = IDLE;
    endcase
  end

  // Datapath
  // NOTE: the divider working registers are reset along with the outputs so an
  // aborted division can never leave a partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_ADD;
      mode_q    <= SH_NONE;
      amt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      phase     <= 1'b0;
      count     <= '0;
      div_q     <= '0;
      div_r     <= '0;
      res_q     <= '0;
      fc_q      <= 1'b0;
      fv_q      <= 1'b0;
      dz_q      <= 1'b0;
      c         <= '0;
      out_valid <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_dz   <= 1'b0;
`ifdef ULA_REMAINDER_EN
      rem_q     <= '0;
      r         <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q   <= op_e'(crtl_ula);
          mode_q <= shift_e'(crtl_des);
          amt_q  <= des_amt;
          a_q    <= a;
          b_q    <= b;
          phase  <= 1'b0;
          count  <= '0;
          div_q  <= a;
          div_r  <= '0;
        end
        EXEC: begin
          if (!phase) begin
            res_q <= alu_res;
            fc_q  <= alu_c;
            fv_q  <= alu_v;
            dz_q  <= alu_dz;
            phase <= 1'b1;
`ifdef ULA_REMAINDER_EN
            rem_q <= (op_q == OP_DIV) ? a_q : '0;
`endif
          end else begin
            c         <= shifted;
            flag_z    <= (shifted == '0);
            flag_c    <= fc_q;
            flag_v    <= fv_q;
            flag_dz   <= dz_q;
            out_valid <= 1'b1;
`ifdef ULA_REMAINDER_EN
            r         <= rem_q;
`endif
          end
        end
        DIV: begin
          div_q <= div_q_next;
          div_r <= div_r_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            res_q <= div_q_next;
            fc_q  <= 1'b0;
            fv_q  <= 1'b0;
            dz_q  <= 1'b0;
            phase <= 1'b1;
`ifdef ULA_REMAINDER_EN
            rem_q <= div_r_next;
`endif
          end
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
